acc_cpu_core: RTL and testbench

- Parametrised multi-cycle accumulator processor core, successor to the fixed 8-bit sysbus CPU.
- Generalised word/opcode/address widths; internal synchronous program/data memory with a load/readback port.
- Adds logic ops, carry/zero flags, conditional branches, immediate load, valid/ready I/O handshakes and HALT.
- Sits under the board top level; seven-segment and switch logic connect via acc_out, out_data, in_data.

---
 rtl/acc_cpu_core.sv | 225 ++++++++++++++++++++++
 tb/tb_acc_cpu_core.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator processor with internal program/data
// memory, carry/zero flags, conditional branches and valid/ready I/O.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               begin execution at address 0 (IDLE/HALTED only)
//   prog_we/addr/wdata  memory load port (IDLE/HALTED only)
//   prog_rdata          registered readback of mem[prog_addr] (IDLE/HALTED only)
//   in_data/in_valid    input port, consumed while in_ready is high
//   in_ready            core is waiting in IN_WAIT
//   out_data/out_valid  output register, held until out_ready
//   out_ready           consumer accepts out_data
//   acc_out, pc_out     accumulator and program counter
//   z_flag, c_flag      zero and carry flags
//   busy, halted        state is not IDLE/HALTED; state is HALTED
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with stable data until that edge.
module acc_cpu_core #(
  parameter int WORD_W = 12,
  parameter int OP_W   = 4,
  parameter int A_W    = WORD_W - OP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [A_W-1:0]    prog_addr,
  input  logic [WORD_W-1:0] prog_wdata,
  output logic [WORD_W-1:0] prog_rdata,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] acc_out,
  output logic [A_W-1:0]    pc_out,
  output logic              z_flag,
  output logic              c_flag,
  output logic              busy,
  output logic              halted
);

  localparam int DEPTH = 2 ** A_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_IN_WAIT  = 3'd4;
  localparam logic [2:0] S_OUT_WAIT = 3'd5;
  localparam logic [2:0] S_HALTED   = 3'd6;

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JZ    = OP_W'(8);
  localparam logic [OP_W-1:0] OP_JC    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_IN    = OP_W'(10);
  localparam logic [OP_W-1:0] OP_OUT   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LDI   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(15);

  logic [2:0]        r_state;
  logic [WORD_W-1:0] r_acc, r_ir, r_mdr, r_out_data, r_prog_rdata;
  logic [A_W-1:0]    r_pc;
  logic              r_z, r_c, r_out_valid, r_in_ready;
  logic [WORD_W-1:0] r_mem [DEPTH];

  logic              w_ctl;
  logic [OP_W-1:0]   w_op, w_fetch_op;
  logic [A_W-1:0]    w_addr;
  logic [WORD_W-1:0] w_fetch_word, w_imm, w_acc_new;
  logic [WORD_W:0]   w_sum, w_diff;
  logic              w_acc_we, w_c_we, w_c_new;
  logic              w_mem_we;
  logic [A_W-1:0]    w_mem_waddr;
  logic [WORD_W-1:0] w_mem_wdata;

  assign w_ctl        = (r_state == S_IDLE) || (r_state == S_HALTED);
  assign w_op         = r_ir[WORD_W-1 -: OP_W];
  assign w_addr       = r_ir[A_W-1:0];
  assign w_fetch_word = r_mem[r_pc];
  assign w_fetch_op   = w_fetch_word[WORD_W-1 -: OP_W];
  // Bit WORD_W is the carry of the sum and the unsigned borrow of the difference.
  assign w_sum        = {1'b0, r_acc} + {1'b0, r_mdr};
  assign w_diff       = {1'b0, r_acc} - {1'b0, r_mdr};

  // Accumulator / carry update selected by the opcode in EXEC.
  always_comb begin
    w_imm            = '0;
    w_imm[A_W-1:0]   = w_addr;
    w_acc_we         = 1'b0;
    w_acc_new        = r_acc;
    w_c_we           = 1'b0;
    w_c_new          = r_c;
    case (w_op)
      OP_LOAD: begin w_acc_we = 1'b1; w_acc_new = r_mdr; end
      OP_ADD:  begin
        w_acc_we = 1'b1; w_acc_new = w_sum[WORD_W-1:0];
        w_c_we   = 1'b1; w_c_new   = w_sum[WORD_W];
      end
      OP_SUB:  begin
        w_acc_we = 1'b1; w_acc_new = w_diff[WORD_W-1:0];
        w_c_we   = 1'b1; w_c_new   = w_diff[WORD_W];
      end
      OP_AND:  begin w_acc_we = 1'b1; w_acc_new = r_acc & r_mdr; end
      OP_OR:   begin w_acc_we = 1'b1; w_acc_new = r_acc | r_mdr; end
      OP_XOR:  begin w_acc_we = 1'b1; w_acc_new = r_acc ^ r_mdr; end
      OP_LDI:  begin w_acc_we = 1'b1; w_acc_new = w_imm; end
      default: ;
    endcase
  end

  // Single memory write port shared by the load port and STORE.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = prog_addr;
    w_mem_wdata = prog_wdata;
    if (!reset) begin
      if (w_ctl && prog_we) begin
        w_mem_we = 1'b1;
      end else if (r_state == S_EXEC && w_op == OP_STORE) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = w_addr;
        w_mem_wdata = r_acc;
      end
    end
  end

  // Memory contents survive reset, so this array has no reset branch.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_pc         <= '0;
      r_ir         <= '0;
      r_mdr        <= '0;
      r_out_data   <= '0;
      r_prog_rdata <= '0;
      r_z          <= 1'b0;
      r_c          <= 1'b0;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          r_prog_rdata <= r_mem[prog_addr];
          if (start) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir    <= w_fetch_word;
          r_pc    <= r_pc + {{(A_W-1){1'b0}}, 1'b1};
          // HALT is recognised straight from the fetched word: no operand needed.
          r_state <= (w_fetch_op == OP_HALT) ? S_HALTED : S_DECODE;
        end
        S_DECODE: begin
          r_mdr   <= r_mem[w_addr];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          if (w_acc_we) begin
            r_acc <= w_acc_new;
            r_z   <= (w_acc_new == '0);
          end
          if (w_c_we) r_c <= w_c_new;
          case (w_op)
            OP_JMP:  r_pc <= w_addr;
            OP_JZ:   if (r_z) r_pc <= w_addr;
            OP_JC:   if (r_c) r_pc <= w_addr;
            OP_IN:   begin r_in_ready <= 1'b1; r_state <= S_IN_WAIT; end
            OP_OUT:  begin
              r_out_data  <= r_acc;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT_WAIT;
            end
            OP_HALT: r_state <= S_HALTED;
            default: ;
          endcase
        end
        S_IN_WAIT: begin
          if (in_valid) begin
            r_acc      <= in_data;
            r_z        <= (in_data == '0);
            r_in_ready <= 1'b0;
            r_state    <= S_FETCH;
          end
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign prog_rdata = r_prog_rdata;
  assign in_ready   = r_in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign acc_out    = r_acc;
  assign pc_out     = r_pc;
  assign z_flag     = r_z;
  assign c_flag     = r_c;
  assign busy       = !w_ctl;
  assign halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Testbench for acc_cpu_core: directed scenarios plus random programs checked
// against an instruction-level reference model; OUT words go through a
// scoreboard queue popped by an independent monitor.
`timescale 1ns/1ps
module tb_acc_cpu_core;
  localparam int W  = 12;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [W-1:0]  prog_wdata = '0;
  logic [W-1:0]  prog_rdata;
  logic [W-1:0]  in_data;
  logic          in_valid, in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  acc_out;
  logic [AW-1:0] pc_out;
  logic          z_flag, c_flag, busy, halted;

  // directed and random drivers for the handshake inputs
  bit            rand_mode = 1'b0;
  logic          dir_out_ready = 1'b0, rnd_out_ready = 1'b0;
  logic          dir_in_valid = 1'b0, rnd_in_valid = 1'b0;
  logic [W-1:0]  dir_in_data = '0, rnd_in_data = '0;
  assign out_ready = rand_mode ? rnd_out_ready : dir_out_ready;
  assign in_valid  = rand_mode ? rnd_in_valid  : dir_in_valid;
  assign in_data   = rand_mode ? rnd_in_data   : dir_in_data;

  acc_cpu_core dut (
    .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_rdata(prog_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .pc_out(pc_out), .z_flag(z_flag), .c_flag(c_flag),
    .busy(busy), .halted(halted)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_err = 0;
  int           n_xfer = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  bit           in_hs = 1'b0;
  int           in_idx = 0;
  logic [W-1:0] in_vals[256];

  // reference model state
  int m_mem[256];
  int m_acc = 0, m_z = 0, m_c = 0, m_pc = 0, m_in_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: a transfer occurs at the next rising edge when both are high
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL out_unexpected: got %0h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", out_data, mon_exp);
      end
    end
    in_hs = in_valid && in_ready;
  end

  // random consumer / producer
  always @(posedge clock) begin
    #1;
    if (rand_mode) begin
      rnd_out_ready = ($urandom_range(0, 1) == 1);
      if (in_hs) begin
        in_idx++;
        rnd_in_valid = 1'b0;
      end
      if (!rnd_in_valid && $urandom_range(0, 2) == 0) begin
        rnd_in_valid = 1'b1;
        rnd_in_data  = in_vals[in_idx];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_word(input int a, input int d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_wdata = W'(d);
    @(posedge clock); #1;
    prog_we = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [W-1:0] d);
    prog_addr = AW'(a);
    @(posedge clock); #1;
    d = prog_rdata;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(posedge clock); #1; n++; end
    if (!halted) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: got running expected halted", name);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // instruction-level reference: runs m_mem from address 0 until HALT
  task automatic model_run();
    int pc = 0, steps = 0, instr, op, a, mv;
    bit done = 1'b0;
    while (!done && steps < 1000) begin
      instr = m_mem[pc];
      pc    = (pc + 1) % 256;
      op    = instr / 256;
      a     = instr % 256;
      mv    = m_mem[a];
      steps++;
      case (op)
        0:  begin m_acc = mv; m_z = (m_acc == 0); end
        1:  m_mem[a] = m_acc;
        2:  begin m_acc = m_acc + mv; m_c = (m_acc > 4095); m_acc = m_acc % 4096; m_z = (m_acc == 0); end
        3:  begin m_c = (m_acc < mv); m_acc = (m_acc - mv + 4096) % 4096; m_z = (m_acc == 0); end
        4:  begin m_acc = m_acc & mv; m_z = (m_acc == 0); end
        5:  begin m_acc = m_acc | mv; m_z = (m_acc == 0); end
        6:  begin m_acc = m_acc ^ mv; m_z = (m_acc == 0); end
        7:  pc = a;
        8:  if (m_z != 0) pc = a;
        9:  if (m_c != 0) pc = a;
        10: begin m_acc = int'(in_vals[m_in_idx]); m_in_idx++; m_z = (m_acc == 0); end
        11: exp_q.push_back(W'(m_acc));
        12: begin m_acc = a; m_z = (m_acc == 0); end
        15: done = 1'b1;
        default: ;
      endcase
    end
    m_pc = pc;
  endtask

  // ---------------- main sequence ----------------
  logic [W-1:0] rd;
  int cyc, n, xfer0, op, a;

  initial begin
    for (int i = 0; i < 256; i++)
      in_vals[i] = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(0, 4095));

    // reset values while reset is held
    run_cycles(2);
    check("rst_acc", acc_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_flags", {z_flag, c_flag}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_prog_rdata", prog_rdata, 0);
    reset = 1'b0;
    run_cycles(1);

    // T1: LDI 5, ADD @20, STORE @21, HALT
    load_word(0, 'hC05); load_word(1, 'h214); load_word(2, 'h115); load_word(3, 'hF00);
    load_word(20, 7); load_word(21, 0);
    start_run();
    cyc = 0;
    while (!halted && cyc < 100) begin @(posedge clock); #1; cyc++; end
    check("t1_halt_cycles", cyc, 10);
    check("t1_acc", acc_out, 12);
    check("t1_halted", halted, 1);
    check("t1_busy", busy, 0);
    check("t1_pc", pc_out, 4);
    read_word(21, rd);
    check("t1_mem21", rd, 12);

    // T2: LOAD 0xFFF, ADD 1 -> 0 with carry, JC 40
    load_word(0, 'h01E); load_word(1, 'h21F); load_word(2, 'h928); load_word(40, 'hF00);
    load_word(30, 'hFFF); load_word(31, 1);
    start_run();
    run_cycles(9);
    check("t2_acc", acc_out, 0);
    check("t2_z", z_flag, 1);
    check("t2_c", c_flag, 1);
    check("t2_jc_pc", pc_out, 40);
    wait_halt("t2", 50);
    check("t2_halt_pc", pc_out, 41);

    // T3: LDI 2, SUB 3 -> 0xFFF with borrow, JZ 40 not taken
    load_word(0, 'hC02); load_word(1, 'h320); load_word(2, 'h828); load_word(3, 'hF00);
    load_word(32, 3);
    start_run();
    run_cycles(6);
    check("t3_acc", acc_out, 'hFFF);
    check("t3_c", c_flag, 1);
    check("t3_z", z_flag, 0);
    wait_halt("t3", 50);
    check("t3_pc_seq", pc_out, 4);

    // T4: OUT with consumer stalled 5 cycles
    load_word(0, 'hC5A); load_word(1, 'hB00); load_word(2, 'hC01); load_word(3, 'hF00);
    exp_q.push_back(W'('h05A));
    start_run();
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clock); #1; n++; end
    check("t4_out_seen", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_data", out_data, 'h05A);
      run_cycles(1);
    end
    xfer0 = n_xfer;
    dir_out_ready = 1'b1;
    run_cycles(1);
    dir_out_ready = 1'b0;
    check("t4_valid_drop", out_valid, 0);
    check("t4_one_xfer", n_xfer - xfer0, 1);
    wait_halt("t4", 50);
    check("t4_next_acc", acc_out, 1);
    check("t4_out_kept", out_data, 'h05A);

    // T5: IN with in_valid 3 cycles late, data 0
    load_word(0, 'hC07); load_word(1, 'hA00); load_word(2, 'hF00);
    start_run();
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clock); #1; n++; end
    for (int k = 0; k < 3; k++) begin
      check("t5_ready_wait", in_ready, 1);
      run_cycles(1);
    end
    check("t5_ready_still", in_ready, 1);
    dir_in_valid = 1'b1; dir_in_data = '0;
    run_cycles(1);
    dir_in_valid = 1'b0;
    check("t5_ready_drop", in_ready, 0);
    wait_halt("t5", 50);
    check("t5_acc", acc_out, 0);
    check("t5_z", z_flag, 1);

    // T6: reset during OUT_WAIT; load port ignored while busy
    load_word(50, 'h111);
    load_word(0, 'hC33); load_word(1, 'hB00); load_word(2, 'hF00);
    exp_q.push_back(W'('h033));
    start_run();
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clock); #1; n++; end
    check("t6_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pc", pc_out, 0);
    check("t6_rst_acc", acc_out, 0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    read_word(1, rd);
    check("t6_mem_kept", rd, 'hB00);
    exp_q.push_back(W'('h033));
    start_run();
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clock); #1; n++; end
    load_word(50, 'hABC);
    pulse_reset();
    read_word(50, rd);
    check("t6_busy_write", rd, 'h111);

    // random programs against the reference model
    m_acc = 0; m_z = 0; m_c = 0; m_in_idx = 0;
    rand_mode = 1'b1;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 12; i++) begin
        op = $urandom_range(0, 14);
        if (op == 7 || op == 8 || op == 9) a = $urandom_range(i + 1, 12);
        else if (op == 12) a = $urandom_range(0, 255);
        else a = 100 + $urandom_range(0, 15);
        m_mem[i] = op * 256 + a;
      end
      m_mem[12] = 'hF00;
      for (int i = 100; i < 116; i++) m_mem[i] = $urandom_range(0, 4095);
      for (int i = 0; i < 13; i++) load_word(i, m_mem[i]);
      for (int i = 100; i < 116; i++) load_word(i, m_mem[i]);
      model_run();
      start_run();
      wait_halt("rand", 3000);
      check("rand_acc", acc_out, m_acc);
      check("rand_z", z_flag, m_z);
      check("rand_c", c_flag, m_c);
      check("rand_pc", pc_out, m_pc);
      check("rand_out_drained", exp_q.size(), 0);
      for (int i = 100; i < 116; i++) begin
        read_word(i, rd);
        check("rand_mem", rd, m_mem[i]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
